// File: rtl/sobel_window_3x3.sv
// rtl/sobel_window_3x3.sv - 3x3 Sobel window, |Gx|+|Gy| magnitude saturated to 8 bits
// Three-stage pipeline: window capture, gradients, magnitude with valid/frame-done strobes.
module sobel_window_3x3 #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] PixTop,
    input  logic [7:0] PixMid,
    input  logic [7:0] PixBot,
    output logic [7:0] EdgeOut,
    output logic       EdgeValid,
    output logic       FrameDone
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [7:0]        win_q [3][3];
    logic [7:0]        win_d [3][3];
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              complete_q, complete_d;
    logic              last_q, last_d;
    logic signed [10:0] gx_q, gx_d;
    logic signed [10:0] gy_q, gy_d;
    logic              valid2_q, valid2_d;
    logic              last2_q, last2_d;
    logic [7:0]        edge_out_q, edge_out_d;
    logic              edge_valid_q, edge_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [10:0]       abs_gx, abs_gy, mag;

    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return signed'({3'b000, p});
    endfunction

    // S1: window shift and position counters, advancing only on enabled edges
    always_comb begin
        win_d      = win_q;
        col_d      = col_q;
        row_d      = row_q;
        complete_d = 1'b0;
        last_d     = 1'b0;
        if (Enable) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = PixTop;
            win_d[1][2] = PixMid;
            win_d[2][2] = PixBot;
            complete_d  = (col_q >= CW'(2)) && (row_q >= RW'(2));
            last_d      = (col_q == COL_LAST) && (row_q == ROW_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // S2: gradients from the captured window
    always_comb begin
        gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        valid2_d = complete_q;
        last2_d  = last_q;
    end

    // S3: magnitude and saturation; EdgeOut holds between results
    always_comb begin
        abs_gx       = gx_q[10] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_gy       = gy_q[10] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag          = abs_gx + abs_gy;
        edge_out_d   = edge_out_q;
        edge_valid_d = valid2_q;
        frame_done_d = valid2_q && last2_q;
        if (valid2_q) begin
            edge_out_d = (mag > 11'd255) ? 8'hFF : mag[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            col_q        <= '0;
            row_q        <= '0;
            complete_q   <= 1'b0;
            last_q       <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            valid2_q     <= 1'b0;
            last2_q      <= 1'b0;
            edge_out_q   <= '0;
            edge_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= win_d;
            col_q        <= col_d;
            row_q        <= row_d;
            complete_q   <= complete_d;
            last_q       <= last_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            valid2_q     <= valid2_d;
            last2_q      <= last2_d;
            edge_out_q   <= edge_out_d;
            edge_valid_q <= edge_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign EdgeOut   = edge_out_q;
    assign EdgeValid = edge_valid_q;
    assign FrameDone = frame_done_q;

endmodule

// File: doc/sobel_window_3x3.md
# sobel_window_3x3

Downstream stage of the 64-cell line-buffer FIFO pair in the Sobel edge-detection datapath. It takes the three vertically aligned pixels presented each enabled cycle (raw input plus the two line-delayed FIFO outputs) and builds a 3x3 sliding window. It computes |Gx|+|Gy| saturated to 8 bits and emits one result per interior pixel, with a valid strobe and an end-of-frame pulse.

## Interface
- IMG_WIDTH, 64, pixels per line; must equal the line-buffer FIFO depth.
- IMG_HEIGHT, 64, lines per frame.
- CLK  input  1  single clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Enable  input  1  pixel-valid; the same signal that drives the line-buffer FIFOs.
- PixTop  input  8  pixel (r-2, c), output of the second FIFO.
- PixMid  input  8  pixel (r-1, c), output of the first FIFO.
- PixBot  input  8  pixel (r, c), raw stream input.
- EdgeOut  output  8  saturated gradient magnitude for centre pixel (r-1, c-1).
- EdgeValid  output  1  one-cycle strobe qualifying EdgeOut.
- FrameDone  output  1  one-cycle pulse, coincident with the last EdgeValid of a frame.

## Operation
- Window W[i][j]: i = 0 is the top row, j = 0 is the oldest column.
- On an edge with Enable=1:
  - Every row shifts left: W[i][0]<=W[i][1], W[i][1]<=W[i][2].
  - The new column enters: W[0][2]<=PixTop, W[1][2]<=PixMid, W[2][2]<=PixBot.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) tag the sampled pixel.
  - col increments on each enabled edge.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0 and the next frame starts.
- Window is complete when the sampled pixel has row>=2 and col>=2.
  - Borders are not output.
  - Windows that straddle a line wrap (col<2) are masked.
  - Windows built from stale or previous-frame FIFO contents (row<2) are masked.
  - Each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) results; 3844 at the defaults.
- With Enable=0, the window and counters hold.
- Arithmetic (all signed, 11 bits):
  - Gx = (W02 + 2*W12 + W22) - (W00 + 2*W10 + W20)
  - Gy = (W20 + 2*W21 + W22) - (W00 + 2*W01 + W02)
  - Mag = |Gx| + |Gy|, range 0..2040, 11-bit unsigned.
  - EdgeOut = Mag if Mag <= 255, else 255.
- Pipeline stages:
  - S1: window registers and a complete flag (advance only on Enable).
  - S2: Gx, Gy and valid registered.
  - S3: EdgeOut, EdgeValid and FrameDone registered.
  - S2 and S3 run every cycle regardless of Enable.
  - A result whose window was captured on an enabled edge drains even if Enable drops.
  - S1's complete flag is cleared on non-enabled edges, so a held window produces no duplicate result.
- FrameDone asserts in S3 together with the result for the window completed by the sampled pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

## Timing
- Reset values (on the edge where Reset=1): EdgeOut=0, EdgeValid=0, FrameDone=0, col=0, row=0, window=0, all pipeline valid flags 0.
- Reset has priority over Enable.
- Reset mid-frame discards every in-flight result: no EdgeValid on the edges following the reset edge until a new complete window has propagated.
- Latency: the pixel sampled at enabled edge k completes the window at edge k. EdgeOut and EdgeValid are visible after edge k+2, i.e. 2 cycles later.
- Throughput: one result per enabled cycle.
  - Back-to-back enabled cycles give back-to-back EdgeValid.
  - Gaps in Enable appear as gaps in EdgeValid, shifted by exactly 2 cycles.
- EdgeOut holds its last value when EdgeValid=0; it is not cleared.
- FrameDone is never asserted without EdgeValid.

## Test plan
- Reset: Reset=1 for 3 cycles with random pixel inputs and Enable=1 -> EdgeOut=0, EdgeValid=0, FrameDone=0 throughout and for the 2 cycles after Reset is released.
- Flat frame: 64x64 pixels all equal to 100, drive PixTop, PixMid and PixBot as the FIFOs would (delays of 64 and 128 enabled cycles), Enable=1 continuously -> exactly 3844 EdgeValid pulses, all with EdgeOut=0, and exactly one FrameDone, coincident with the final EdgeValid.
- Vertical step: pixel = 0 for col<32, 200 for col>=32 -> centre columns 31 and 32 give Gx=800 and EdgeOut=255; every other interior column gives 0; rows 1..62 are identical.
- Horizontal ramp: pixel = col -> every result has Gx=8, Gy=0, EdgeOut=8. The first EdgeValid appears 2 cycles after the enabled edge sampling (2,2).
- Enable gaps: same ramp with Enable toggled pseudo-randomly -> identical 3844-value sequence. Each EdgeValid lags its completing enabled edge by exactly 2 cycles, with no duplicate results during holds.
- Mid-frame reset: Reset for 1 cycle at (row 10, col 20) -> no EdgeValid on the following 2 edges. Counters restart at 0, and a fresh full frame then yields 3844 results and one FrameDone.
